// File: rtl/dm_arb.sv
// Two-master round-robin arbiter in front of a single-port data memory.
// Optional wait statistics are enabled by defining DM_ARB_STATS_EN.
module dm_arb #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [8:2]  m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [8:2]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] rdata,
  output logic        dm_we,
  output logic [8:2]  dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
`ifdef DM_ARB_STATS_EN
  output logic [15:0] m0_wait_cnt,
  output logic [15:0] m1_wait_cnt,
`endif
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_ptr
);

  // Handshake: a master raises req with a stable command and holds both until
  // it sees gnt; the access happens in the gnt cycle and the command is not
  // latched, so it must stay valid through that cycle. Reads return one cycle
  // later as an rvalid pulse with the shared rdata.

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t      r_state;
  logic        r_ptr;
  logic [31:0] r_rdata;
  logic        r_rvalid0;
  logic        r_rvalid1;

  logic        w_elig0;
  logic        w_elig1;
  state_t      w_next;
  logic        w_we;
  logic [8:2]  w_addr;
  logic [31:0] w_wdata;
  logic        w_rd0;
  logic        w_rd1;

  // A master that is granted this cycle sits out the next decision.
  assign w_elig0 = m0_req && (r_state != G0);
  assign w_elig1 = m1_req && (r_state != G1);

  assign w_rd0 = (r_state == G0) && !m0_we;
  assign w_rd1 = (r_state == G1) && !m1_we;

  always_comb begin
    w_next = IDLE;
    if (w_elig0 && w_elig1)
      w_next = r_ptr ? G1 : G0;
    else if (w_elig0)
      w_next = G0;
    else if (w_elig1)
      w_next = G1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= RR_INIT;
      r_rdata   <= 32'h0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_next;
      if (w_next == G0)
        r_ptr <= 1'b1;
      else if (w_next == G1)
        r_ptr <= 1'b0;
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0 || w_rd1)
        r_rdata <= dm_rdata;
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = 32'h0;
    case (r_state)
      G0: begin
        w_we    = m0_we;
        w_addr  = m0_addr;
        w_wdata = m0_wdata;
      end
      G1: begin
        w_we    = m1_we;
        w_addr  = m1_addr;
        w_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // Reset gates the write strobe immediately so an in-flight grant is harmless.
  assign dm_we     = w_we && !rst;
  assign dm_addr   = w_addr;
  assign dm_wdata  = w_wdata;

  assign m0_gnt    = (r_state == G0);
  assign m1_gnt    = (r_state == G1);
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign rdata     = r_rdata;

  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

`ifdef DM_ARB_STATS_EN
  logic [15:0] r_wait0;
  logic [15:0] r_wait1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait0 <= 16'h0;
      r_wait1 <= 16'h0;
    end else begin
      if (m0_req && !m0_gnt && (r_wait0 != 16'hFFFF))
        r_wait0 <= r_wait0 + 16'd1;
      if (m1_req && !m1_gnt && (r_wait1 != 16'hFFFF))
        r_wait1 <= r_wait1 + 16'd1;
    end
  end

  assign m0_wait_cnt = r_wait0;
  assign m1_wait_cnt = r_wait1;
`endif

endmodule
